// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI mode-0 master transfer controller.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_e;

  // Counter width for a modulus of v (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Client-side start/busy/done handshake of the SPI master controller.
interface spi_master_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  start;
  logic [DATA_WIDTH-1:0] txData;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] rxData;

  modport master (output start, txData, input busy, done, rxData);
  modport slave  (input start, txData, output busy, done, rxData);
endinterface

// File: rtl/spi_sclk_tick_gen.sv
// Half-period tick generator for SCLK; counter is held clear while disabled.
module spi_sclk_tick_gen
  import spi_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 20
) (
  input  logic clkIn,
  input  logic rstN,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = cnt_width(HALF_PERIOD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // tick is registered one count early so the consumer acts exactly every HALF_PERIOD edges.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (en) begin
      cnt_d  = (cnt_q == CW'(HALF_PERIOD - 1)) ? '0 : cnt_q + CW'(1);
      tick_d = (cnt_q == CW'(HALF_PERIOD - 2));
    end
  end

  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one full-duplex MSB-first word per accepted start,
// with chip-select framing and a minimum deselect gap between words.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned FREQ_SCALE = 40,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CS_GAP     = 4
) (
  input  logic                     clkIn,
  input  logic                     rstN,
  spi_master_ctrl_if.slave         bus,
  output logic                     sclk,
  output logic                     csN,
  output logic                     mosi,
  input  logic                     miso
);

  localparam int unsigned H  = FREQ_SCALE / 2;
  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
  localparam int unsigned GW = cnt_width(CS_GAP);

  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  en_q, en_d;
  logic                  tick;

  spi_sclk_tick_gen #(.HALF_PERIOD(H)) u_tick (
    .clkIn (clkIn),
    .rstN  (rstN),
    .en    (en_q),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    en_d       = en_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          tx_shift_d = bus.txData;
          cs_n_d     = 1'b0;
          mosi_d     = bus.txData[DATA_WIDTH-1];
          busy_d     = 1'b1;
          en_d       = 1'b1;
          bit_cnt_d  = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          sclk_d     = 1'b1;
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], miso};
          bit_cnt_d  = BW'(1);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
            // Rotate so the next bit is always at DATA_WIDTH-2; the last bit stays on mosi through HOLD.
            if (bit_cnt_q < BW'(DATA_WIDTH)) begin
              mosi_d     = tx_shift_q[DATA_WIDTH-2];
              tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], tx_shift_q[DATA_WIDTH-1]};
            end else begin
              state_d = HOLD;
            end
          end else begin
            sclk_d     = 1'b1;
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], miso};
            bit_cnt_d  = bit_cnt_q + BW'(1);
          end
        end
      end
      HOLD: begin
        if (tick) begin
          cs_n_d    = 1'b1;
          mosi_d    = 1'b0;
          rx_data_d = rx_shift_q;
          done_d    = 1'b1;
          en_d      = 1'b0;
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GW'(CS_GAP - 1)) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      en_q       <= en_d;
    end
  end

  assign sclk       = sclk_q;
  assign csN        = cs_n_q;
  assign mosi       = mosi_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.rxData = rx_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: a mode-0 slave model feeds miso, a
// monitor checks each completed word against expectations queued at issue time.
module tb_spi_master_ctrl;

  localparam int unsigned FS  = 40;
  localparam int unsigned W   = 16;
  localparam int unsigned GAP = 4;
  localparam int unsigned H   = FS / 2;
  localparam int unsigned FS2 = 4;
  localparam int unsigned W2  = 2;
  localparam int unsigned H2  = FS2 / 2;

  typedef struct {
    logic [W-1:0] tx;
    logic [W-1:0] rx;
  } exp_t;

  typedef struct {
    bit           loop;
    logic [W-1:0] word;
  } slv_t;

  logic clkIn = 1'b0;
  logic rstN  = 1'b0;
  always #5 clkIn = ~clkIn;

  logic sclk, csN, mosi, miso;
  logic sclk2, csN2, mosi2;

  spi_master_ctrl_if #(.DATA_WIDTH(W))  bus ();
  spi_master_ctrl_if #(.DATA_WIDTH(W2)) bus2 ();

  spi_master_ctrl #(.FREQ_SCALE(FS), .DATA_WIDTH(W), .CS_GAP(GAP)) dut (
    .clkIn (clkIn), .rstN (rstN), .bus (bus),
    .sclk (sclk), .csN (csN), .mosi (mosi), .miso (miso)
  );

  spi_master_ctrl #(.FREQ_SCALE(FS2), .DATA_WIDTH(W2), .CS_GAP(GAP)) dut2 (
    .clkIn (clkIn), .rstN (rstN), .bus (bus2),
    .sclk (sclk2), .csN (csN2), .mosi (mosi2), .miso (mosi2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clkIn) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // Scoreboards and slave-model state
  exp_t          exp_q[$];
  slv_t          slave_q[$];
  logic [W2-1:0] exp2_q[$];

  logic         slave_loop = 1'b0;
  logic         slave_bit  = 1'b0;
  logic [W-1:0] slave_word = '0;
  int           fall_cnt   = 0;
  int           rise_cyc[$];
  logic [W-1:0] mosi_seq   = '0;
  int           e0         = 0;
  int           cs_high_run = 0;
  bit           b2b        = 1'b0;
  logic         csN_p = 1'b1, sclk_p = 1'b0;

  int   e0_2 = 0;
  int   hi2  = 0;
  logic csN2_p = 1'b1, sclk2_p = 1'b0;

  assign miso = slave_loop ? mosi : slave_bit;

  // Slave model and output monitor, sampled on the falling clock edge.
  always @(negedge clkIn) begin
    if (!rstN) begin
      rise_cyc.delete();
      mosi_seq    = '0;
      fall_cnt    = 0;
      slave_loop  = 1'b0;
      slave_word  = '0;
      slave_bit   = 1'b0;
      cs_high_run = 0;
      csN_p = 1'b1; sclk_p = 1'b0;
      csN2_p = 1'b1; sclk2_p = 1'b0;
      hi2 = 0;
    end else begin
      if (csN_p && !csN) begin
        if (b2b) check("cs_gap_b2b", 64'(cs_high_run), 64'(GAP + 1));
        e0 = cyc;
        rise_cyc.delete();
        mosi_seq = '0;
        fall_cnt = 0;
        if (slave_q.size() > 0) begin
          slv_t s;
          s = slave_q.pop_front();
          slave_loop = s.loop;
          slave_word = s.word;
        end
      end
      if (!sclk_p && sclk) begin
        rise_cyc.push_back(cyc);
        mosi_seq = {mosi_seq[W-2:0], mosi};
      end
      if (sclk_p && !sclk) fall_cnt++;
      slave_bit   = (fall_cnt < int'(W)) ? slave_word[W-1-fall_cnt] : 1'b0;
      cs_high_run = csN ? cs_high_run + 1 : 0;

      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 64'(1), 64'(0));
        end else begin
          exp_t e;
          bit   ok;
          e = exp_q.pop_front();
          check("rxData", 64'(bus.rxData), 64'(e.rx));
          check("done_latency", 64'(cyc - e0), 64'(W * FS + H));
          check("sclk_rise_count", 64'(rise_cyc.size()), 64'(W));
          ok = (rise_cyc.size() == int'(W));
          foreach (rise_cyc[k]) if (rise_cyc[k] != e0 + int'(H) + k * int'(FS)) ok = 1'b0;
          check("sclk_rise_timing", 64'(ok), 64'(1));
          check("mosi_at_rises", 64'(mosi_seq), 64'(e.tx));
          check("csN_high_at_done", 64'(csN), 64'(1));
        end
      end
      csN_p  = csN;
      sclk_p = sclk;

      // Small-parameter instance
      if (csN2_p && !csN2) e0_2 = cyc;
      if (sclk2) hi2++;
      if (sclk2_p && !sclk2) begin
        check("sclk2_high_cycles", 64'(hi2), 64'(H2));
        hi2 = 0;
      end
      if (bus2.done) begin
        if (exp2_q.size() == 0) begin
          check("done2_unexpected", 64'(1), 64'(0));
        end else begin
          check("rxData2", 64'(bus2.rxData), 64'(exp2_q.pop_front()));
          check("done2_latency", 64'(cyc - e0_2), 64'(W2 * FS2 + H2));
        end
      end
      csN2_p  = csN2;
      sclk2_p = sclk2;
    end
  end

  task automatic step();
    @(negedge clkIn);
    #1;
  endtask

  task automatic wait_accept(input string name, output bit acc);
    int n = 0;
    do begin
      step();
      n++;
    end while (!bus.busy && n < 10);
    acc = bus.busy;
    check(name, 64'(bus.busy), 64'(1));
  endtask

  task automatic xfer(input logic [W-1:0] tx, input bit loop, input logic [W-1:0] sw, input bit hold);
    bit acc;
    int n = 0;
    slave_q.push_back('{loop, sw});
    exp_q.push_back('{tx, loop ? tx : sw});
    bus.start  = 1'b1;
    bus.txData = tx;
    wait_accept("accept", acc);
    if (!hold) bus.start = 1'b0;
    bus.txData = W'($urandom);
    while (bus.busy && n < 3000) begin
      step();
      n++;
    end
    check("busy_release", 64'(bus.busy), 64'(0));
  endtask

  task automatic xfer2(input logic [W2-1:0] tx);
    bit acc;
    int n = 0;
    exp2_q.push_back(tx);
    bus2.start  = 1'b1;
    bus2.txData = tx;
    do begin
      step();
      n++;
    end while (!bus2.busy && n < 10);
    check("accept2", 64'(bus2.busy), 64'(1));
    bus2.start  = 1'b0;
    bus2.txData = W2'($urandom);
    n = 0;
    while (bus2.busy && n < 200) begin
      step();
      n++;
    end
    check("busy2_release", 64'(bus2.busy), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_csN"},    64'(csN),        64'(1));
    check({tag, "_sclk"},   64'(sclk),       64'(0));
    check({tag, "_mosi"},   64'(mosi),       64'(0));
    check({tag, "_busy"},   64'(bus.busy),   64'(0));
    check({tag, "_done"},   64'(bus.done),   64'(0));
    check({tag, "_rxData"}, 64'(bus.rxData), 64'(0));
  endtask

  task automatic abort_xfer(input logic [W-1:0] tx);
    bit acc;
    int n = 0;
    int start_cyc;
    slave_q.push_back('{1'b1, '0});
    exp_q.push_back('{tx, tx});
    bus.start  = 1'b1;
    bus.txData = tx;
    wait_accept("abort_accept", acc);
    start_cyc = cyc;
    bus.start = 1'b0;
    while (cyc < start_cyc + 300 && n < 1000) begin
      step();
      n++;
    end
    check("sclk_high_before_abort", 64'(sclk), 64'(1));
    rstN = 1'b0;
    #1;
    check_reset_outputs("abort");
    exp_q.delete();
    slave_q.delete();
    step();
    step();
    rstN = 1'b1;
    step();
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.txData  = '0;
    bus2.start  = 1'b0;
    bus2.txData = '0;
    rstN        = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    check("reset_csN2", 64'(csN2), 64'(1));
    rstN = 1'b1;
    step();

    xfer(16'hA5C3, 1'b1, 16'h0000, 1'b0);
    xfer(16'hFFFF, 1'b0, 16'h1234, 1'b0);
    for (int i = 0; i < 4; i++)
      xfer(W'($urandom), 1'($urandom), W'($urandom), 1'b0);

    // Start held high across consecutive words.
    xfer(W'($urandom), 1'b0, W'($urandom), 1'b1);
    b2b = 1'b1;
    xfer(W'($urandom), 1'b0, W'($urandom), 1'b1);
    xfer(W'($urandom), 1'b1, W'($urandom), 1'b1);
    xfer(W'($urandom), 1'b0, W'($urandom), 1'b0);
    b2b = 1'b0;

    abort_xfer(16'h5AA5);
    xfer(16'h0F0F, 1'b0, W'($urandom), 1'b0);
    xfer(16'h0F0F, 1'b1, 16'h0000, 1'b0);

    xfer2(2'b10);
    for (int i = 0; i < 4; i++) xfer2(W2'($urandom));

    repeat (10) step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    check("scoreboard2_drained", 64'(exp2_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

SPI mode-0 master transfer controller that sequences the SPI serial clock and chip select for one fixed-width, full-duplex word per request. It sits between the on-chip client (ADC sampling logic or a configuration FSM) and the off-chip SPI device. It derives SCLK from the board clock via an internal half-period tick generator. It owns csN, sclk and mosi, samples miso, and provides a start/busy/done handshake to the client.

## Interface
- FREQ_SCALE, 40, board-to-SPI clock ratio; SCLK period = FREQ_SCALE clkIn cycles; must be even and >= 4
- DATA_WIDTH, 16, bits per transfer, MSB first; >= 2
- CS_GAP, 4, minimum clkIn cycles csN stays high between transfers; >= 1
- clkIn  in  1  board clock; all logic on rising edge
- rstN  in  1  asynchronous, active-low reset
- start  in  1  transfer request; sampled only while busy=0
- txData  in  DATA_WIDTH  word to shift out; latched on accepted start
- busy  out  1  high from accepted start until gap ends; reset 0
- done  out  1  one-cycle pulse when rxData is valid; reset 0
- rxData  out  DATA_WIDTH  last received word; reset 0; holds until the next done
- sclk  out  1  SPI clock, idle low (CPOL=0); reset 0
- csN  out  1  chip select, active low; reset 1
- mosi  out  1  serial data out; reset 0; 0 when idle
- miso  in  1  serial data in; sampled on sclk rising edges

## Operation
- H = FREQ_SCALE/2 clkIn cycles per SCLK half-period.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: csN=1, sclk=0, mosi=0, busy=0. On start=1, latch txData into shiftReg, set csN=0, mosi=txData[MSB] and busy=1, enable tick gen, and go to SETUP.
- SETUP: after H cycles, sclk<=1 (rising edge 1), capture miso into rxShift LSB, go to SHIFT.
- SHIFT: each tick toggles sclk.
  - Rising edge: shift miso into rxShift.
  - Falling edge: if fewer than DATA_WIDTH rising edges have occurred, put the next tx bit on mosi. After the falling edge that follows rising edge DATA_WIDTH, go to HOLD with mosi unchanged.
- HOLD: after H cycles with sclk=0, set csN=1, mosi=0, rxData<=rxShift and done=1 for one cycle. Disable tick gen, go to GAP.
- GAP: count CS_GAP cycles, then busy<=0 and go to IDLE.
- Ignore start while busy=1; txData changes after acceptance have no effect.
- Bit counter width: $clog2(DATA_WIDTH+1); tick counter width: $clog2(H); tick counter wraps from H-1 to 0.
- When rstN is asserted mid-transfer, all outputs go to reset values immediately (asynchronously), the FSM goes to IDLE, the partial word is discarded and rxData is cleared.

## Timing
- Let E0 be the clkIn edge that accepts start. csN falls and mosi = MSB are valid after E0.
- Rising edge k (k = 1..DATA_WIDTH) occurs at E0 + H + (k-1)·FREQ_SCALE; the matching falling edge occurs H cycles later.
- csN rises and done pulses at E0 + DATA_WIDTH·FREQ_SCALE + H.
- busy falls CS_GAP cycles after done. The earliest next start is accepted on the cycle after busy falls.
- Each mosi bit is stable for H cycles before and after the rising edge that samples it (the last bit is held through HOLD).
- The sclk duty cycle is exactly 50%; there are no glitches on sclk or csN.

## Structure
- Package spi_pkg: spi_state_e enum (IDLE, SETUP, SHIFT, HOLD, GAP).
- Sub-module spi_sclk_tick_gen (params HALF_PERIOD; ports clkIn, rstN, en, tick):
  - tick pulses every HALF_PERIOD cycles while en=1.
  - The counter clears when en=0, so the first tick comes HALF_PERIOD cycles after enable.

## Test plan
- Reset: rstN=0 -> csN=1, sclk=0, mosi=0, busy=0, done=0, rxData=0.
- Loopback, FREQ_SCALE=40, DATA_WIDTH=16, miso tied to mosi, txData=0xA5C3:
  - done at E0+660 with rxData=0xA5C3.
  - Exactly 16 sclk rising edges, spaced 40 cycles apart.
- Slave model returns 0x1234 while txData=0xFFFF -> rxData=0x1234; the mosi sequence observed at rising edges is all ones.
- Back-to-back: start held high continuously -> csN high for CS_GAP+1=5 cycles between words; no start accepted while busy.
- Mid-transfer abort: rstN=0 at E0+300 -> csN=1 and sclk=0 immediately. After release, the next transfer of 0x0F0F completes correctly.
- Parameter corner: FREQ_SCALE=4, DATA_WIDTH=2, txData=2'b10 -> done at E0+10, sclk high for 2 cycles per bit.
